pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed ID/EX pipeline register: one generic stage register for any RISC-V pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a 2-entry skid buffer for full-throughput stalls, and flush with a selectable data-clearing mode.
- Adds saturating stall and flush event counters for performance debug.
- Payload is split into a data field (PCs, immediates, operands) and a control field (regWrite, MemWrite, Branch, Jump, ALU_Sel, Resultsrc, register indices).

Parameters:
- DATA_W, 160, data payload width (default holds 5 x 32-bit fields).
- CTRL_W, 26, control payload width.
- CLEAR_DATA, 1, 1 = data entries zeroed on reset/flush; 0 = data retained, only valid and control cleared.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept; registered, equals !skid_v.
- in_data  input  DATA_W  upstream data payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  entry available downstream; equals main_v.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main entry data.
- out_ctrl  output  CTRL_W  main entry control; forced to 0 whenever main_v=0.
- flush  input  1  kill all held entries and the current input.
- level  output  2  occupancy: 0, 1 or 2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- flush_cnt  output  CNT_W  flush cycles that killed at least one valid entry, saturating.

Behaviour:
- Only clk and reset: one clock domain, synchronous active-high reset.
- State: main entry (main_v, main_d, main_c) and skid entry (skid_v, skid_d, skid_c).
- Invariant: skid_v=1 implies main_v=1.
- push = in_valid & in_ready; pop = main_v & out_ready.
- Reset (highest priority):
  - main_v, skid_v, all control entries, stall_cnt and flush_cnt go to 0.
  - Data entries go to 0 if CLEAR_DATA=1, else are undefined.
  - After reset: in_ready=1, out_valid=0, out_ctrl=0, level=0.
- Flush (next priority; applies in the cycle it is high):
  - Next edge: main_v=0, skid_v=0, main_c=0, skid_c=0. Data entries are zeroed if CLEAR_DATA=1, otherwise held.
  - Any push in that cycle is discarded. Any pop in that cycle still completes downstream.
  - flush_cnt increments if main_v|skid_v was 1 before the edge.
  - Flush asserted for consecutive cycles keeps the stage empty.
- Normal operation, transitions by (main_v, skid_v):
  - EMPTY (0,0): push -> main <= in, go to ONE. Otherwise stay.
  - ONE (1,0):
    - push & pop -> main <= in, stay.
    - pop only -> main_v=0, go to EMPTY.
    - push only -> skid <= in, go to FULL.
    - neither -> hold.
  - FULL (1,1), in_ready=0:
    - pop -> main <= skid, skid_v=0, go to ONE.
    - else hold.
- Latency and throughput:
  - EMPTY input to out_valid: 1 cycle.
  - Sustained throughput with out_ready=1: 1 entry/cycle.
  - Entries leave in strict FIFO order; none duplicated or lost except by flush.
- Flow control:
  - in_ready deasserts one cycle after the skid fills, so an upstream stall reacts registered, with no combinational path from out_ready to in_ready.
  - Held outputs (out_data, out_ctrl) stay stable while out_valid=1 and out_ready=0.
- Counters:
  - stall_cnt increments in any cycle with main_v & !out_ready and no reset, including flush cycles.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
- level = main_v + skid_v.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_ctrl=0, level=0, both counters 0.
- Stream of data 0x1..0x8 with ctrl 0x01..0x08, in_valid=1, out_ready=1 -> outputs 0x1..0x8 one per cycle, 1-cycle latency, level=1, stall_cnt=0.
- Push 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, in_ready=0 from the next cycle, 0xC not accepted, level=2. Release out_ready -> 0xA, 0xB, 0xC in order, stall_cnt equals the held cycles.
- FULL with ctrl 0x3FFFFFF, then flush=1 for one cycle with in_valid=1 and in_data=0xD -> next cycle out_valid=0, out_ctrl=0, level=0, flush_cnt=1, 0xD never appears. Run once with CLEAR_DATA=1 (out_data=0) and once with CLEAR_DATA=0 (out_data retained).
- Flush on an empty stage, and reset while FULL -> flush_cnt unchanged on the empty flush; reset yields the reset state with no stale output.
- CNT_W=4 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
// Generic elastic pipeline stage register for any RISC-V pipeline boundary.
// It holds a main entry that drives the outputs and a skid entry that absorbs
// the one extra beat accepted while the downstream stall propagates upstream.
// in_ready is a plain register output (!skid_v), so there is no combinational
// path from out_ready to in_ready. A flush kills every held entry and the
// current input. Two saturating counters record stall and flush events.
module pipe_stage_elastic #(
    parameter int DATA_W     = 160,
    parameter int CTRL_W     = 26,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Entry state: main drives the outputs, skid is only valid while main is
    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] main_c;
    logic [CTRL_W-1:0] skid_c;

    // Handshake qualifiers and load selects
    logic push;
    logic pop;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign push = in_valid & in_ready;
    assign pop  = main_v & out_ready;

    // main takes the input when it is empty or is being emptied this cycle;
    // a FULL stage never pushes, so these two cases cover every main refill
    // from the input. The skid refills main whenever it holds something and
    // main is popped. The skid takes the input only when main stays occupied.
    assign load_main_in   = push & (~main_v | pop);
    assign load_main_skid = skid_v & pop;
    assign load_skid_in   = push & main_v & ~pop;

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign out_ctrl  = main_v ? main_c : '0;
    assign level     = {1'b0, main_v} + {1'b0, skid_v};

    // Occupancy state machine over (main_v, skid_v): EMPTY, ONE, FULL
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            unique case ({main_v, skid_v})
                2'b00: begin
                    if (push) main_v <= 1'b1;
                end
                2'b10: begin
                    if (pop && !push)
                        main_v <= 1'b0;
                    else if (push && !pop)
                        skid_v <= 1'b1;
                end
                2'b11: begin
                    if (pop) skid_v <= 1'b0;
                end
                default: begin
                    // skid without main breaks the invariant; drop to EMPTY
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

    // Control payload: always cleared by reset and flush so no stale
    // regWrite/MemWrite can survive a kill
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_c <= '0;
            skid_c <= '0;
        end else begin
            if (load_main_skid)
                main_c <= skid_c;
            else if (load_main_in)
                main_c <= in_ctrl;
            if (load_skid_in)
                skid_c <= in_ctrl;
        end
    end

    generate
        if (CLEAR_DATA != 0) begin : g_data_clear
            // Data payload zeroed by reset and flush
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    main_d <= '0;
                    skid_d <= '0;
                end else begin
                    if (load_main_skid)
                        main_d <= skid_d;
                    else if (load_main_in)
                        main_d <= in_data;
                    if (load_skid_in)
                        skid_d <= in_data;
                end
            end
        end else begin : g_data_keep
            // Data payload retained across reset and flush; only loads move it
            always_ff @(posedge clk) begin
                if (!reset && !flush) begin
                    if (load_main_skid)
                        main_d <= skid_d;
                    else if (load_main_in)
                        main_d <= in_data;
                    if (load_skid_in)
                        skid_d <= in_data;
                end
            end
        end
    endgenerate

    // Stall counter: main held against back-pressure, flush cycles included
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (main_v && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Flush counter: only flushes that actually killed a valid entry
    always_ff @(posedge clk) begin
        if (reset)
            flush_cnt <= '0;
        else if (flush && (main_v || skid_v) && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
    end

endmodule
